// File: rtl/cap_pkg.sv
// Shared capture-buffer definitions: command codes, FSM states and default sizes.
package cap_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 10;

    localparam logic [7:0] CMD_TRIG_RUN         = 8'd0;
    localparam logic [7:0] CMD_TRIG_HALT        = 8'd1;
    localparam logic [7:0] CMD_CAP_SET_PRETRIG  = 8'd9;
    localparam logic [7:0] CMD_CAP_SET_POSTTRIG = 8'd10;
    localparam logic [7:0] CMD_CAP_READ_START   = 8'd11;
    localparam logic [7:0] CMD_CAP_SET_DIVIDER  = 8'd12;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFill    = 3'd1,
        StArmed   = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4,
        StReadout = 3'd5
    } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset on contents.
module capture_ram #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [2**AddrWidth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_buffer_ctrl.sv
// Pre/post-trigger ring-buffer capture with oldest-first readout.
// Define CAP_DECIMATE_EN to store only every (div+1)-th sample.
module capture_buffer_ctrl
    import cap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  inclk,
    input  logic                  rst_n,
    input  logic [7:0]            command,
    input  logic [23:0]           config_in,
    input  logic [DATA_WIDTH-1:0] inport,
    input  logic                  triggered,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [2:0]            cap_state,
    output logic                  done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;

    localparam addr_t AddrOne = addr_t'(1);
    localparam cnt_t  CntOne  = cnt_t'(1);

    cap_state_t            state_q, state_d;
    logic [7:0]            prev_cmd_q, prev_cmd_d;
    logic                  trig_prev_q, trig_prev_d;
    addr_t                 pretrig_q, pretrig_d, posttrig_q, posttrig_d;
    addr_t                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    addr_t                 start_addr_q, start_addr_d, fill_cnt_q, fill_cnt_d;
    cnt_t                  eff_post_q, eff_post_d, post_cnt_q, post_cnt_d;
    cnt_t                  rd_total_q, rd_total_d, rd_cnt_q, rd_cnt_d;
    logic                  rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;

    logic  ram_we, ram_re, sample_en, arm, trig_rise;
    logic  cmd_edge, cmd_halt, cmd_run, cmd_pre, cmd_post, cmd_read;
    addr_t cfg_addr;
    cnt_t  room, eff_post_new;
    logic  unused_cfg;

    assign cfg_addr   = config_in[ADDR_WIDTH-1:0];
    assign unused_cfg = ^config_in;
    assign cmd_edge   = command != prev_cmd_q;
    assign cmd_halt   = cmd_edge && (command == CMD_TRIG_HALT);
    assign cmd_run    = cmd_edge && (command == CMD_TRIG_RUN);
    assign cmd_pre    = cmd_edge && (command == CMD_CAP_SET_PRETRIG);
    assign cmd_post   = cmd_edge && (command == CMD_CAP_SET_POSTTRIG);
    assign cmd_read   = cmd_edge && (command == CMD_CAP_READ_START);
    assign trig_rise  = triggered & ~trig_prev_q;

    // Post-trigger length is clamped so the whole window fits in the ring.
    assign room         = cnt_t'(DEPTH) - {1'b0, pretrig_q};
    assign eff_post_new = ({1'b0, posttrig_q} < room) ? {1'b0, posttrig_q} : room;

`ifdef CAP_DECIMATE_EN
    logic [15:0] div_q, div_d, div_cnt_q, div_cnt_d;
    logic        cmd_div;
    assign cmd_div   = cmd_edge && (command == CMD_CAP_SET_DIVIDER);
    assign sample_en = (div_cnt_q == '0);
`else
    assign sample_en = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        prev_cmd_d   = command;
        trig_prev_d  = triggered;
        pretrig_d    = pretrig_q;
        posttrig_d   = posttrig_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        start_addr_d = start_addr_q;
        fill_cnt_d   = fill_cnt_q;
        eff_post_d   = eff_post_q;
        post_cnt_d   = post_cnt_q;
        rd_total_d   = rd_total_q;
        rd_cnt_d     = rd_cnt_q;
        rd_pend_d    = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        arm          = 1'b0;
`ifdef CAP_DECIMATE_EN
        div_d        = div_q;
        div_cnt_d    = (div_cnt_q == div_q) ? '0 : div_cnt_q + 16'd1;
`endif
        if (cmd_halt) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (cmd_pre) pretrig_d = cfg_addr;
                    if (cmd_post) posttrig_d = (cfg_addr == '0) ? AddrOne : cfg_addr;
`ifdef CAP_DECIMATE_EN
                    if (cmd_div) div_d = config_in[15:0];
`endif
                    if (cmd_run) begin
                        arm = 1'b1;
                    end else if (cmd_read && (state_q == StDone)) begin
                        rd_ptr_d = start_addr_q;
                        rd_cnt_d = '0;
                        state_d  = StReadout;
                    end
                end
                StFill: begin
                    if (sample_en) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AddrOne;
                        fill_cnt_d = fill_cnt_q + AddrOne;
                        if (fill_cnt_d == pretrig_q) state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (sample_en) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AddrOne;
                    end
                    // The trigger sample is the one at wr_ptr, stored now or on the next tick.
                    if (trig_rise) begin
                        start_addr_d = wr_ptr_q - pretrig_q;
                        post_cnt_d   = cnt_t'(sample_en);
                        state_d      = StPost;
                    end
                end
                StPost: begin
                    if (post_cnt_q == eff_post_q) begin
                        state_d = StDone;
                    end else if (sample_en) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AddrOne;
                        post_cnt_d = post_cnt_q + CntOne;
                    end
                end
                StReadout: begin
                    if (cmd_run) begin
                        arm = 1'b1;
                    end else if (rd_req && (rd_cnt_q != rd_total_q)) begin
                        ram_re    = 1'b1;
                        rd_pend_d = 1'b1;
                        rd_ptr_d  = rd_ptr_q + AddrOne;
                        rd_cnt_d  = rd_cnt_q + CntOne;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (arm) begin
                wr_ptr_d   = '0;
                fill_cnt_d = '0;
                eff_post_d = eff_post_new;
                rd_total_d = {1'b0, pretrig_q} + eff_post_new;
                state_d    = (pretrig_q == '0) ? StArmed : StFill;
`ifdef CAP_DECIMATE_EN
                div_cnt_d  = '0;
`endif
            end
        end
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? ram_rdata : rd_data_q;
        done_d     = (state_d == StDone) || (state_d == StReadout);
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prev_cmd_q   <= CMD_TRIG_HALT;
            trig_prev_q  <= 1'b0;
            pretrig_q    <= '0;
            posttrig_q   <= addr_t'(DEPTH / 2);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            start_addr_q <= '0;
            fill_cnt_q   <= '0;
            eff_post_q   <= '0;
            post_cnt_q   <= '0;
            rd_total_q   <= '0;
            rd_cnt_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
`ifdef CAP_DECIMATE_EN
            div_q        <= '0;
            div_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prev_cmd_q   <= prev_cmd_d;
            trig_prev_q  <= trig_prev_d;
            pretrig_q    <= pretrig_d;
            posttrig_q   <= posttrig_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            start_addr_q <= start_addr_d;
            fill_cnt_q   <= fill_cnt_d;
            eff_post_q   <= eff_post_d;
            post_cnt_q   <= post_cnt_d;
            rd_total_q   <= rd_total_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
`ifdef CAP_DECIMATE_EN
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
`endif
        end
    end

    capture_ram #(
        .DataWidth(DATA_WIDTH),
        .AddrWidth(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (inclk),
        .we_i   (ram_we),
        .waddr_i(wr_ptr_q),
        .wdata_i(inport),
        .re_i   (ram_re),
        .raddr_i(rd_ptr_q),
        .rdata_o(ram_rdata)
    );

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign cap_state = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Randomised bench for capture_buffer_ctrl against a window-level model of the capture.
module tb_capture_buffer_ctrl;
    import cap_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;
    localparam int          DEPTH = 32;
    localparam int          MAXL  = 256;
    localparam logic [7:0]  NOP   = 8'hFF;

    logic          inclk = 1'b0;
    logic          rst_n;
    logic [7:0]    command;
    logic [23:0]   config_in;
    logic [DW-1:0] inport;
    logic          triggered;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    cap_state;
    logic          done;

    capture_buffer_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .inclk    (inclk),
        .rst_n    (rst_n),
        .command  (command),
        .config_in(config_in),
        .inport   (inport),
        .triggered(triggered),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .cap_state(cap_state),
        .done     (done)
    );

    always #5 inclk = ~inclk;

    int checks = 0;
    int errors = 0;

    // Model state: configuration in effect, per-sample stimulus and the expected window.
    int            m_pre;
    int            m_post;
    logic          tp   [0:MAXL];     // tp[0]: level in the RUN cycle; tp[k+1]: level with sample k
    logic [DW-1:0] hist [0:MAXL-1];   // inport presented with sample k
    logic [DW-1:0] win  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge inclk);
    endtask

    task automatic send_cmd(input logic [7:0] c, input int cfg);
        command   = c;
        config_in = 24'(cfg);
        cyc();
        command   = NOP;
        cyc();
    endtask

    task automatic set_cfg(input int pre, input int post);
        send_cmd(CMD_TRIG_HALT, 0);
        send_cmd(CMD_CAP_SET_PRETRIG, pre);
        send_cmd(CMD_CAP_SET_POSTTRIG, post);
        m_pre  = pre;
        m_post = (post == 0) ? 1 : post;
    endtask

    task automatic pat_level(input int rise, input bit ctr, input int base);
        for (int i = 0; i <= MAXL; i++) tp[i] = (i >= rise + 1);
        for (int k = 0; k < MAXL; k++) hist[k] = ctr ? DW'(k + base) : DW'($urandom);
    endtask

    task automatic pat_random(input int pre);
        tp[0] = 1'($urandom_range(0, 1));
        for (int i = 1; i <= MAXL; i++) tp[i] = ($urandom_range(0, 5) == 0) ? ~tp[i-1] : tp[i-1];
        tp[pre+21] = 1'b0;
        tp[pre+22] = 1'b1;
        for (int k = 0; k < MAXL; k++) hist[k] = DW'($urandom);
    endtask

    // First rising edge of triggered at or after the first armed sample.
    function automatic int find_trig(input int pre);
        for (int k = pre; k < MAXL; k++) if (tp[k+1] && !tp[k]) return k;
        return 0;
    endfunction

    task automatic do_capture(input bit halt_in_post);
        int t;
        int eff;
        eff = (m_post < DEPTH - m_pre) ? m_post : DEPTH - m_pre;
        t   = find_trig(m_pre);
        command   = CMD_TRIG_RUN;
        triggered = tp[0];
        inport    = DW'($urandom);
        cyc();
        check_eq("state_after_run", 32'(cap_state), (m_pre == 0) ? 32'd2 : 32'd1);
        command = NOP;
        for (int k = 0; k < MAXL; k++) begin
            inport    = hist[k];
            triggered = tp[k+1];
            cyc();
            if (done) break;
            if (halt_in_post && cap_state == 3'd3) break;
        end
        if (halt_in_post) begin
            check_eq("in_post", 32'(cap_state), 32'd3);
            command = CMD_TRIG_HALT;
            cyc();
            command = NOP;
            check_eq("halt_state", 32'(cap_state), 32'd0);
            check_eq("halt_done", 32'(done), 32'd0);
        end else begin
            check_eq("done", 32'(done), 32'd1);
            check_eq("state_done", 32'(cap_state), 32'd4);
            win.delete();
            for (int j = 0; j < m_pre + eff; j++) win.push_back(hist[t - m_pre + j]);
        end
    endtask

    task automatic do_readout(input int extra, input bit b2b);
        logic [DW-1:0] exp_q [$];
        int            due_q [$];
        logic [DW-1:0] e;
        logic          exp_v;
        int            reqs;
        int            issued;
        int            last;
        command = CMD_CAP_READ_START;
        cyc();
        command = NOP;
        check_eq("state_readout", 32'(cap_state), 32'd5);
        check_eq("done_readout", 32'(done), 32'd1);
        reqs   = win.size() + extra;
        issued = 0;
        last   = -10;
        for (int c = 0; c < 400; c++) begin
            exp_v = (due_q.size() > 0) && (due_q[0] == c);
            check_eq("rd_valid", 32'(rd_valid), 32'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                check_eq("rd_data", 32'(rd_data), 32'(e));
            end
            if (issued >= reqs && due_q.size() == 0 && c > last + 2) break;
            rd_req = 1'b0;
            if (issued < reqs && (b2b || $urandom_range(0, 1) == 1)) begin
                rd_req = 1'b1;
                if (issued < win.size()) begin
                    due_q.push_back(c + 2);
                    exp_q.push_back(win[issued]);
                end
                issued++;
                last = c;
            end
            cyc();
        end
        rd_req = 1'b0;
        check_eq("rd_left", 32'(due_q.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        command   = CMD_TRIG_HALT;
        config_in = '0;
        inport    = '0;
        triggered = 1'b0;
        rd_req    = 1'b0;
        m_pre     = 0;
        m_post    = DEPTH / 2;
        repeat (2) cyc();
        check_eq("rst_state", 32'(cap_state), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        cyc();
        check_eq("post_rst_state", 32'(cap_state), 32'd0);

        // Counter data, trigger at value 20: window 16..23, ninth request ignored.
        set_cfg(4, 4);
        pat_level(20, 1'b1, 0);
        do_capture(1'b0);
        do_readout(1, 1'b1);

        // No history, trigger on the first armed sample: 5,6,7.
        set_cfg(0, 3);
        pat_level(0, 1'b1, 5);
        do_capture(1'b0);
        do_readout(2, 1'b1);

        // Trigger long after the write pointer has wrapped.
        set_cfg(8, 8);
        pat_level(100, 1'b0, 0);
        do_capture(1'b0);
        do_readout(1, 1'b0);

        // Post length clamped to DEPTH - pretrig: full 32-sample window.
        set_cfg(30, 10);
        pat_level(40, 1'b0, 0);
        do_capture(1'b0);
        do_readout(1, 1'b1);

        // Edge during fill is lost; level already high when armed needs a low first.
        set_cfg(10, 5);
        pat_level(0, 1'b0, 0);
        for (int i = 0; i <= MAXL; i++) tp[i] = (i >= 4 && i <= 15) || (i >= 19);
        do_capture(1'b0);
        do_readout(0, 1'b0);

        // RUN straight from READOUT re-arms with the same settings.
        pat_random(m_pre);
        do_capture(1'b0);
        do_readout(1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            set_cfg($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            pat_random(m_pre);
            do_capture(1'b0);
            do_readout($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // HALT in POST, then READ_START and rd_req from IDLE are ignored.
        set_cfg(4, 20);
        pat_level(30, 1'b0, 0);
        do_capture(1'b1);
        command = CMD_CAP_READ_START;
        cyc();
        command = NOP;
        rd_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("halt_no_read_state", 32'(cap_state), 32'd0);
            check_eq("halt_no_rd_valid", 32'(rd_valid), 32'd0);
        end
        rd_req = 1'b0;

        // Asynchronous reset mid-fill, then capture with reset-default settings.
        set_cfg(6, 4);
        command = CMD_TRIG_RUN;
        cyc();
        command = NOP;
        repeat (3) cyc();
        check_eq("fill_state", 32'(cap_state), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(cap_state), 32'd0);
        check_eq("async_rst_done", 32'(done), 32'd0);
        cyc();
        rst_n  = 1'b1;
        m_pre  = 0;
        m_post = DEPTH / 2;
        pat_random(m_pre);
        do_capture(1'b0);
        do_readout(1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
